// File: rtl/mopshub_seq_pkg.sv
// ------------------------------------------------------------------
// mopshub_seq_pkg: shared state encoding and mode bit indices. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mopshub_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_TRIM    = 4'd1,
    ST_SIGNON  = 4'd2,
    ST_SELECT  = 4'd3,
    ST_RX      = 4'd4,
    ST_ENDWAIT = 4'd5,
    ST_GAP     = 4'd6,
    ST_TX      = 4'd7,
    ST_ADV     = 4'd8,
    ST_NEXT    = 4'd9,
    ST_DONE    = 4'd10
  } state_t;

  localparam int MODE_TRIM   = 0;
  localparam int MODE_RX     = 1;
  localparam int MODE_TX     = 2;
  localparam int MODE_CUSTOM = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mopshub_test_sequencer_if.sv
// ------------------------------------------------------------------
// mopshub_test_sequencer_if: generator handshakes and core controls. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface mopshub_test_sequencer_if #(
  parameter int N_BUSES = 16,
  parameter int CNT_W   = 8
);
  localparam int SEL_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;

  logic               start;
  logic               abort;
  logic [3:0]         mode;
  logic [N_BUSES-1:0] bus_mask;
  logic               end_power_init;
  logic               sign_on;
  logic               rx_end;
  logic               tx_end;
  logic               custom_end;
  logic               osc_trim_en;
  logic               test_rx;
  logic               test_tx;
  logic               test_advanced;
  logic               endwait_all;
  logic [SEL_W-1:0]   bus_sel;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   pass_cnt;
  logic [CNT_W-1:0]   fail_cnt;
  logic               err_timeout;

  modport slave (
    input  start, abort, mode, bus_mask, end_power_init, sign_on,
           rx_end, tx_end, custom_end,
    output osc_trim_en, test_rx, test_tx, test_advanced, endwait_all,
           bus_sel, busy, done, pass_cnt, fail_cnt, err_timeout
  );

  modport master (
    output start, abort, mode, bus_mask, end_power_init, sign_on,
           rx_end, tx_end, custom_end,
    input  osc_trim_en, test_rx, test_tx, test_advanced, endwait_all,
           bus_sel, busy, done, pass_cnt, fail_cnt, err_timeout
  );
endinterface

`default_nettype wire

// File: rtl/mopshub_seq_timer.sv
// ------------------------------------------------------------------
// mopshub_seq_timer: loadable down-counter, expired while count is zero. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mopshub_seq_timer #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_val,
  output logic                  expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/mopshub_test_sequencer.sv
// ------------------------------------------------------------------
// mopshub_test_sequencer: trim, sign-on and per-bus RX/TX/custom test flow. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mopshub_test_sequencer
  import mopshub_seq_pkg::*;
#(
  parameter int N_BUSES        = 16,
  parameter int GAP_CYCLES     = 120,
  parameter int ENDWAIT_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  mopshub_test_sequencer_if.slave seq
);

  localparam int SEL_W = (N_BUSES > 1) ? $clog2(N_BUSES) : 1;
  localparam int TMR_MAX = max3(GAP_CYCLES, ENDWAIT_CYCLES, TIMEOUT_CYCLES);
  localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX + 1) : 1;
  localparam logic [SEL_W-1:0] LAST_BUS = SEL_W'(N_BUSES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [3:1]         mode_q, mode_d;
  logic [N_BUSES-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic               err_q, err_d;
  logic               ran_q, ran_d;
  logic               osc_q, rx_q, tx_q, adv_q, ew_q, busy_q, done_q;
  logic               osc_d, rx_d, tx_d, adv_d, ew_d, busy_d, done_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_exp;

  mopshub_seq_timer #(.WIDTH(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_exp)
  );

  // Every state entry restarts the shared timer with that state's budget.
  assign tmr_load = (state_d != state_q);

  always_comb begin
    tmr_val = '0;
    case (state_d)
      ST_ENDWAIT: tmr_val = TMR_W'(ENDWAIT_CYCLES - 1);
      ST_GAP:     tmr_val = TMR_W'(GAP_CYCLES - 1);
      ST_TRIM, ST_SIGNON, ST_RX, ST_TX, ST_ADV:
                  tmr_val = TMR_W'(TIMEOUT_CYCLES - 1);
      default:    tmr_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    sel_d   = sel_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    ran_d   = ran_q;

    if (seq.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seq.start) begin
            mode_d  = seq.mode[3:1];
            mask_d  = seq.bus_mask;
            sel_d   = '0;
            pass_d  = '0;
            fail_d  = '0;
            err_d   = 1'b0;
            state_d = seq.mode[MODE_TRIM] ? ST_TRIM : ST_SIGNON;
          end
        end
        ST_TRIM: begin
          if (seq.end_power_init) begin
            state_d = ST_SIGNON;
          end else if (tmr_exp) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_SIGNON: begin
          if (seq.sign_on) begin
            state_d = ST_SELECT;
          end else if (tmr_exp) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_SELECT: begin
          // ran flags a bus that must earn its pass in NEXT; a bus with no
          // phases enabled goes straight there and is credited.
          ran_d = mask_q[sel_q];
          if (!mask_q[sel_q])           state_d = ST_NEXT;
          else if (mode_q[MODE_RX])     state_d = ST_RX;
          else if (mode_q[MODE_TX])     state_d = ST_TX;
          else if (mode_q[MODE_CUSTOM]) state_d = ST_ADV;
          else                          state_d = ST_NEXT;
        end
        ST_RX, ST_TX, ST_ADV: begin
          if ((state_q == ST_RX && seq.rx_end) ||
              (state_q == ST_TX && seq.tx_end) ||
              (state_q == ST_ADV && seq.custom_end)) begin
            if (state_q == ST_RX)                        state_d = ST_ENDWAIT;
            else if (state_q == ST_TX && mode_q[MODE_CUSTOM]) state_d = ST_ADV;
            else                                         state_d = ST_NEXT;
          end else if (tmr_exp) begin
            err_d   = 1'b1;
            ran_d   = 1'b0;
            fail_d  = (fail_q == CNT_MAX) ? fail_q : fail_q + 1'b1;
            state_d = ST_NEXT;
          end
        end
        ST_ENDWAIT: begin
          if (tmr_exp) state_d = ST_GAP;
        end
        ST_GAP: begin
          if (tmr_exp) begin
            if (mode_q[MODE_TX])          state_d = ST_TX;
            else if (mode_q[MODE_CUSTOM]) state_d = ST_ADV;
            else                          state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (ran_q && pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
          if (sel_q == LAST_BUS) begin
            state_d = ST_DONE;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = ST_SELECT;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    osc_d  = (state_d == ST_TRIM);
    rx_d   = (state_d == ST_RX);
    tx_d   = (state_d == ST_TX);
    adv_d  = (state_d == ST_ADV);
    ew_d   = (state_d == ST_ENDWAIT);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
      ran_q   <= 1'b0;
      osc_q   <= 1'b0;
      rx_q    <= 1'b0;
      tx_q    <= 1'b0;
      adv_q   <= 1'b0;
      ew_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      ran_q   <= ran_d;
      osc_q   <= osc_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      adv_q   <= adv_d;
      ew_q    <= ew_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq.osc_trim_en   = osc_q;
  assign seq.test_rx       = rx_q;
  assign seq.test_tx       = tx_q;
  assign seq.test_advanced = adv_q;
  assign seq.endwait_all   = ew_q;
  assign seq.bus_sel       = sel_q;
  assign seq.busy          = busy_q;
  assign seq.done          = done_q;
  assign seq.pass_cnt      = pass_q;
  assign seq.fail_cnt      = fail_q;
  assign seq.err_timeout   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mopshub_test_sequencer.sv
// ------------------------------------------------------------------
// tb_mopshub_test_sequencer: randomized runs against a run-level outcome model. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mopshub_test_sequencer;

  localparam int N  = 16;
  localparam int E  = 2;
  localparam int G  = 20;
  localparam int T  = 100;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mopshub_test_sequencer_if #(.N_BUSES(N), .CNT_W(CW)) sif ();

  mopshub_test_sequencer #(
    .N_BUSES(N), .GAP_CYCLES(G), .ENDWAIT_CYCLES(E), .TIMEOUT_CYCLES(T), .CNT_W(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .seq (sif)
  );

  typedef struct { int bus; int ph; int width; } ev_t;
  typedef struct { int pass; int fail; int err; } res_t;

  ev_t  ev_q[$];
  res_t res_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   w_ph = -1, w_bus = -1, w_kind = 0;  // kind 1: withhold strobe, 2: strobe on timeout cycle
  bit   mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [27:0] out_vec();
    return {sif.osc_trim_en, sif.test_rx, sif.test_tx, sif.test_advanced, sif.endwait_all,
            sif.bus_sel, sif.busy, sif.done, sif.pass_cnt, sif.fail_cnt, sif.err_timeout};
  endfunction

  // Run-level outcome: which phases each bus sees and the final tallies.
  function automatic int model(input logic [3:0] m, input logic [15:0] mk, input int wph,
                               input int wb, input int wk, input int stop_bus);
    res_t r;
    ev_t  e;
    bit   ok;
    r.pass = 0; r.fail = 0; r.err = 0;
    if ((wk == 1 && wph == 0 && m[0]) || (wk == 1 && wph == 4)) begin
      r.err = 1;
      res_q.push_back(r);
      return 0;
    end
    for (int b = 0; b < N; b++) begin
      if (!mk[b]) continue;
      ok = 1'b1;
      for (int ph = 1; ph <= 3; ph++) begin
        if (!m[ph]) continue;
        e.bus = b; e.ph = ph;
        e.width = (wk != 0 && wb == b && wph == ph) ? T : 0;
        ev_q.push_back(e);
        if (b == stop_bus) return r.pass;
        if (wk == 1 && wb == b && wph == ph) begin ok = 1'b0; break; end
      end
      if (ok) r.pass++; else begin r.fail++; r.err = 1; end
    end
    res_q.push_back(r);
    return r.pass;
  endfunction

  initial begin : responder
    logic [3:0] prv, o, s;
    int age[4];
    int dly[4];
    bit held;
    prv = '0;
    sif.end_power_init = 1'b0; sif.sign_on = 1'b0;
    sif.rx_end = 1'b0; sif.tx_end = 1'b0; sif.custom_end = 1'b0;
    forever begin
      @(negedge clk);
      o = {sif.test_advanced, sif.test_tx, sif.test_rx, sif.osc_trim_en};
      s = '0;
      for (int p = 0; p < 4; p++) begin
        held = (w_kind != 0) && (w_ph == p) && (p == 0 || int'(sif.bus_sel) == w_bus);
        if (o[p]) begin
          if (!prv[p]) begin
            age[p] = 0;
            dly[p] = (held && w_kind == 2) ? T - 1 : int'($urandom_range(0, 8));
          end else begin
            age[p]++;
          end
          if (age[p] == dly[p] && !(held && w_kind == 1)) s[p] = 1'b1;
        end else if (cyc % (5 + p) == 0) begin
          s[p] = 1'b1;  // stray strobe outside its phase
        end
      end
      prv = o;
      sif.end_power_init = s[0];
      sif.rx_end         = s[1];
      sif.tx_end         = s[2];
      sif.custom_end     = s[3];
      sif.sign_on        = (w_kind == 1 && w_ph == 4) ? 1'b0 : (cyc % 3 == 0);
    end
  end

  initial begin : monitor
    logic [2:0] mp, o3;
    int rise_c[3];
    int rise_b[3];
    int ew_c, rxf_c, rxf_b, w;
    bit ewp, rxf_v;
    ev_t  ev;
    res_t r;
    mp = '0; ewp = 1'b0; rxf_v = 1'b0; ew_c = 0; rxf_c = 0; rxf_b = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        o3 = {sif.test_advanced, sif.test_tx, sif.test_rx};
        for (int i = 0; i < 3; i++) begin
          if (o3[i] && !mp[i]) begin
            rise_c[i] = cyc;
            rise_b[i] = int'(sif.bus_sel);
            if (i == 1 && rxf_v && rxf_b == int'(sif.bus_sel)) begin
              chk("rx_fall_to_tx_rise", cyc - rxf_c, E + G);
              rxf_v = 1'b0;
            end
          end else if (!o3[i] && mp[i]) begin
            w = cyc - rise_c[i];
            if (i == 0) begin rxf_v = 1'b1; rxf_c = cyc; rxf_b = rise_b[i]; end
            chk("phase_expected", ev_q.size() > 0, 1);
            if (ev_q.size() > 0) begin
              ev = ev_q.pop_front();
              chk("phase_bus_and_kind", rise_b[i] * 4 + i + 1, ev.bus * 4 + ev.ph);
              if (ev.width == 0) chk("phase_width_short", (w >= 1 && w <= 9), 1);
              else               chk("phase_width_timeout", w, ev.width);
            end
          end
        end
        mp = o3;
        if (sif.endwait_all && !ewp) ew_c = cyc;
        if (!sif.endwait_all && ewp) chk("endwait_width", cyc - ew_c, E);
        ewp = sif.endwait_all;
        if (!sif.busy) rxf_v = 1'b0;
        if (sif.done) begin
          chk("done_expected", res_q.size() > 0, 1);
          if (res_q.size() > 0) begin
            r = res_q.pop_front();
            chk("pass_cnt", sif.pass_cnt, r.pass);
            chk("fail_cnt", sif.fail_cnt, r.fail);
            chk("err_timeout", sif.err_timeout, r.err);
          end
          chk("phases_consumed_at_done", ev_q.size(), 0);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (sif.busy && n < 5000) begin @(negedge clk); n++; end
    chk(nm, sif.busy, 0);
  endtask

  task automatic kick(input logic [3:0] m, input logic [15:0] mk);
    @(negedge clk);
    sif.start = 1'b1; sif.mode = m; sif.bus_mask = mk;
    @(negedge clk);
    sif.start = 1'b0; sif.mode = 4'($urandom); sif.bus_mask = 16'($urandom);
    chk("busy_after_start", sif.busy, 1);
    chk("trim_at_cycle1", sif.osc_trim_en, m[0]);
  endtask

  task automatic run(input logic [3:0] m, input logic [15:0] mk, input int wph,
                     input int wb, input int wk);
    int unused_pass;
    w_ph = wph; w_bus = wb; w_kind = wk;
    unused_pass = model(m, mk, wph, wb, wk, -1);
    kick(m, mk);
    wait_idle("run_completes");
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int n, exp_pass, n_done;
    bit found, prev_ew;
    sif.start = 1'b0; sif.abort = 1'b0; sif.mode = '0; sif.bus_mask = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", sif.busy, 0);

    run(4'b1111, 16'hFFFF, -1, -1, 0);
    run(4'b0110, 16'h0005, -1, -1, 0);
    run(4'b1111, 16'hFFFF, 1, 3, 1);
    run(4'b1111, 16'hFFFF, 1, 2, 2);
    run(4'($urandom), 16'h0000, -1, -1, 0);
    run(4'b0110, 16'($urandom) | 16'h0080, 2, 7, 1);
    run(4'b1001, 16'($urandom) | 16'h0400, 3, 10, 2);
    run(4'b1100, 16'($urandom) | 16'h0002, 3, 1, 1);
    run(4'b0011, 16'($urandom), 4, -1, 1);
    run(4'b0001, 16'($urandom), 0, -1, 1);
    run(4'b0000, 16'($urandom), -1, -1, 0);
    for (int r = 0; r < 4; r++)
      run(4'($urandom), 16'($urandom), int'($urandom_range(1, 3)),
          int'($urandom_range(0, N - 1)), int'($urandom_range(0, 2)));

    // abort in the GAP of bus 5
    w_ph = -1; w_bus = -1; w_kind = 0;
    exp_pass = model(4'b0110, 16'hFFFF, -1, -1, 0, 5);
    kick(4'b0110, 16'hFFFF);
    n = 0; found = 1'b0; prev_ew = 1'b0;
    while (!found && n < 5000) begin
      @(negedge clk); n++;
      if (prev_ew && !sif.endwait_all && sif.bus_sel == 4'd5) found = 1'b1;
      prev_ew = sif.endwait_all;
    end
    chk("abort_gap_reached", found, 1);
    @(negedge clk); sif.abort = 1'b1;
    @(negedge clk); sif.abort = 1'b0;
    chk("abort_outputs_clear", {sif.osc_trim_en, sif.test_rx, sif.test_tx,
        sif.test_advanced, sif.endwait_all, sif.busy, sif.done}, 0);
    chk("abort_pass_held", sif.pass_cnt, exp_pass);
    chk("abort_fail_held", sif.fail_cnt, 0);
    n_done = 0;
    repeat (20) begin @(negedge clk); if (sif.done) n_done++; end
    chk("abort_no_done", n_done, 0);
    chk("abort_phases_consumed", ev_q.size(), 0);

    // asynchronous reset while TX is active
    w_ph = -1; w_bus = -1; w_kind = 0;
    exp_pass = model(4'b0110, 16'hFFFF, -1, -1, 0, -1);
    kick(4'b0110, 16'hFFFF);
    n = 0;
    while (!sif.test_tx && n < 5000) begin @(negedge clk); n++; end
    chk("tx_reached", sif.test_tx, 1);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", out_vec(), 0);
    ev_q.delete();
    res_q.delete();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_after_async_reset", sif.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
